// File: rtl/mux_rr_scheduler.sv
// mux_rr_scheduler
// Round-robin scheduler in front of the 3:1 select mux. It arbitrates three
// requesters and holds each grant for a burst of up to HOLD_MAX beats. The
// owner's data is presented through a registered valid/ready output stage.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   ip1..ip3  [WIDTH]    requester data, valid while the matching req is high
//   req1..req3           requester wants the mux
//   gnt1..gnt3           one-hot registered grant
//   sel1..sel3           one-hot mux select, identical to gnt1..gnt3
//   mux_op    [WIDTH]    registered selected data
//   op_valid             mux_op holds a beat not yet taken downstream
//   op_ready             downstream accepts the beat when op_valid is high
module mux_rr_scheduler #(
    parameter int WIDTH    = 4,
    parameter int HOLD_MAX = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] ip1,
    input  logic [WIDTH-1:0] ip2,
    input  logic [WIDTH-1:0] ip3,
    input  logic             req1,
    input  logic             req2,
    input  logic             req3,
    output logic             gnt1,
    output logic             gnt2,
    output logic             gnt3,
    output logic             sel1,
    output logic             sel2,
    output logic             sel3,
    output logic [WIDTH-1:0] mux_op,
    output logic             op_valid,
    input  logic             op_ready
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_OWN  = 1'b1;

    localparam logic [3:0] HOLD_LIMIT = 4'(HOLD_MAX);

    logic [0:0]       state;
    logic [2:0]       gnt;
    logic [1:0]       last;
    logic [3:0]       beats;
    logic [2:0]       req_vec;
    logic             owner_req;
    logic [WIDTH-1:0] owner_data;
    logic             capture;
    logic             last_beat;
    logic [2:0]       win_gnt;
    logic [1:0]       win_idx;

    assign req_vec   = {req3, req2, req1};
    assign owner_req = |(gnt & req_vec);

    // A beat is taken from the owner only when the output register is empty
    // or is being drained on this same edge. A dropped req always wins over
    // a pending capture.
    assign capture   = (state == ST_OWN) && owner_req && (!op_valid || op_ready);
    assign last_beat = capture && (beats == HOLD_LIMIT - 4'd1);

    // Data of the current owner; the grant is one-hot, so a plain priority
    // chain is enough to steer it.
    always_comb begin
        owner_data = '0;
        if (gnt[0]) begin
            owner_data = ip1;
        end else if (gnt[1]) begin
            owner_data = ip2;
        end else if (gnt[2]) begin
            owner_data = ip3;
        end
    end

    // Rotating search for the next owner. It starts just after the previous
    // winner, so the requester served last has the lowest priority.
    always_comb begin
        win_gnt = 3'b000;
        win_idx = last;
        case (last)
            2'd1: begin
                if (req2)      begin win_gnt = 3'b010; win_idx = 2'd2; end
                else if (req3) begin win_gnt = 3'b100; win_idx = 2'd3; end
                else if (req1) begin win_gnt = 3'b001; win_idx = 2'd1; end
            end
            2'd2: begin
                if (req3)      begin win_gnt = 3'b100; win_idx = 2'd3; end
                else if (req1) begin win_gnt = 3'b001; win_idx = 2'd1; end
                else if (req2) begin win_gnt = 3'b010; win_idx = 2'd2; end
            end
            default: begin
                if (req1)      begin win_gnt = 3'b001; win_idx = 2'd1; end
                else if (req2) begin win_gnt = 3'b010; win_idx = 2'd2; end
                else if (req3) begin win_gnt = 3'b100; win_idx = 2'd3; end
            end
        endcase
    end

    // Grant FSM, burst counter and output register.
    // IDLE only arbitrates, which creates the one-cycle bubble between owners.
    // In OWN the stage either captures, holds on a stall, or releases the grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            gnt      <= 3'b000;
            last     <= 2'd3;
            beats    <= 4'd0;
            mux_op   <= '0;
            op_valid <= 1'b0;
        end else if (state == ST_IDLE) begin
            if (op_valid && op_ready) begin
                op_valid <= 1'b0;
            end
            if (|req_vec) begin
                state <= ST_OWN;
                gnt   <= win_gnt;
                last  <= win_idx;
            end
        end else begin
            if (!owner_req) begin
                state <= ST_IDLE;
                gnt   <= 3'b000;
                beats <= 4'd0;
                if (op_valid && op_ready) begin
                    op_valid <= 1'b0;
                end
            end else if (capture) begin
                mux_op   <= owner_data;
                op_valid <= 1'b1;
                if (last_beat) begin
                    state <= ST_IDLE;
                    gnt   <= 3'b000;
                    beats <= 4'd0;
                end else begin
                    beats <= beats + 4'd1;
                end
            end
        end
    end

    assign gnt1 = gnt[0];
    assign gnt2 = gnt[1];
    assign gnt3 = gnt[2];
    assign sel1 = gnt[0];
    assign sel2 = gnt[1];
    assign sel3 = gnt[2];

endmodule

// File: tb/tb_mux_rr_scheduler.sv
// tb_mux_rr_scheduler
// Self-checking bench for mux_rr_scheduler. It runs directed scenarios for
// reset, fairness, early release, backpressure and mid-burst reset. A
// randomized run is then checked every cycle against a behavioural model
// of the arbitration and burst rules.
module tb_mux_rr_scheduler;

    localparam int WIDTH    = 4;
    localparam int HOLD_MAX = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [WIDTH-1:0] ip1, ip2, ip3;
    logic             req1, req2, req3;
    logic             gnt1, gnt2, gnt3;
    logic             sel1, sel2, sel3;
    logic [WIDTH-1:0] mux_op;
    logic             op_valid;
    logic             op_ready;

    logic [2:0] gv;
    logic [2:0] sv;

    int n_cmp  = 0;
    int n_fail = 0;

    // Behavioural model state, used by the random run.
    int         m_owner;
    int         m_last;
    int         m_beats;
    int         m_valid;
    int         m_caps;
    logic [3:0] m_data;

    assign gv = {gnt3, gnt2, gnt1};
    assign sv = {sel3, sel2, sel1};

    mux_rr_scheduler #(
        .WIDTH    (WIDTH),
        .HOLD_MAX (HOLD_MAX)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ip1      (ip1),
        .ip2      (ip2),
        .ip3      (ip3),
        .req1     (req1),
        .req2     (req2),
        .req3     (req3),
        .gnt1     (gnt1),
        .gnt2     (gnt2),
        .gnt3     (gnt3),
        .sel1     (sel1),
        .sel2     (sel2),
        .sel3     (sel3),
        .mux_op   (mux_op),
        .op_valid (op_valid),
        .op_ready (op_ready)
    );

    // Free-running clock, 10 time units per period.
    always #5 clk = ~clk;

    // Watchdog so the run can never hang.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        req1     = 1'b0;
        req2     = 1'b0;
        req3     = 1'b0;
        op_ready = 1'b1;
        ip1      = 4'd2;
        ip2      = 4'd4;
        ip3      = 4'd8;
        repeat (2) tick();
        rst_n = 1'b1;
    endtask

    task automatic model_reset();
        m_owner = 0;
        m_last  = 3;
        m_beats = 0;
        m_valid = 0;
        m_caps  = 0;
        m_data  = 4'd0;
    endtask

    // One clock edge of the scheduler, described by its rules. Requesters
    // are numbered 1..3, and the search starts just after the last winner.
    task automatic model_step(input logic [3:1] r, input logic rdy,
                              input logic [3:0] d1, input logic [3:0] d2,
                              input logic [3:0] d3);
        logic [3:0] d [1:3];
        int         nxt;
        d[1] = d1;
        d[2] = d2;
        d[3] = d3;
        if (m_owner == 0) begin
            nxt = 0;
            for (int k = 1; k <= 3; k++) begin
                int cand;
                cand = ((m_last - 1 + k) % 3) + 1;
                if (nxt == 0 && r[cand]) nxt = cand;
            end
            if (m_valid != 0 && rdy) m_valid = 0;
            if (nxt != 0) begin
                m_owner = nxt;
                m_last  = nxt;
            end
        end else if (!r[m_owner]) begin
            if (m_valid != 0 && rdy) m_valid = 0;
            m_owner = 0;
            m_beats = 0;
        end else if (m_valid == 0 || rdy) begin
            m_data  = d[m_owner];
            m_valid = 1;
            m_beats = m_beats + 1;
            m_caps  = m_caps + 1;
            if (m_beats == HOLD_MAX) begin
                m_owner = 0;
                m_beats = 0;
            end
        end
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        ip1      = 4'b0010;
        ip2      = 4'd4;
        ip3      = 4'd8;
        req1     = 1'b1;
        req2     = 1'b1;
        req3     = 1'b1;
        op_ready = 1'b1;
        repeat (2) tick();
        n_cmp++; if (gv !== 3'b000) begin n_fail++; $display("[TB] FAIL reset_gnt: got %b want 000", gv); end
        n_cmp++; if (sv !== 3'b000) begin n_fail++; $display("[TB] FAIL reset_sel: got %b want 000", sv); end
        n_cmp++; if (mux_op !== 4'd0) begin n_fail++; $display("[TB] FAIL reset_mux_op: got %0d want 0", mux_op); end
        n_cmp++; if (op_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_valid: got %b want 0", op_valid); end
        rst_n = 1'b1;
        tick();
        n_cmp++; if (gv !== 3'b001) begin n_fail++; $display("[TB] FAIL reset_first_gnt: got %b want 001", gv); end
        n_cmp++; if (op_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_first_valid: got %b want 0", op_valid); end
        tick();
        n_cmp++; if (mux_op !== 4'd2) begin n_fail++; $display("[TB] FAIL reset_first_beat: got %0d want 2", mux_op); end
        n_cmp++; if (op_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_first_beat_valid: got %b want 1", op_valid); end
    endtask

    task automatic test_fairness();
        int         grant_owner [$];
        int         grant_cycle [$];
        logic [3:0] beats_seen  [$];
        logic [2:0] prev;
        int         exp_owner [4];
        int         exp_cycle [4];
        logic [3:0] exp_val   [3];
        exp_owner = '{1, 2, 3, 1};
        exp_cycle = '{1, 6, 11, 16};
        exp_val   = '{4'd2, 4'd4, 4'd8};
        do_reset();
        req1 = 1'b1;
        req2 = 1'b1;
        req3 = 1'b1;
        prev = 3'b000;
        for (int c = 1; c <= 22; c++) begin
            tick();
            if (gv != 3'b000 && prev == 3'b000) begin
                grant_owner.push_back(gv == 3'b001 ? 1 : (gv == 3'b010 ? 2 : 3));
                grant_cycle.push_back(c);
            end
            if (op_valid) beats_seen.push_back(mux_op);
            prev = gv;
        end
        n_cmp++;
        if (grant_owner.size() < 4) begin
            n_fail++;
            $display("[TB] FAIL fair_grant_count: got %0d want >=4", grant_owner.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_cmp++; if (grant_owner[i] != exp_owner[i]) begin n_fail++; $display("[TB] FAIL fair_order[%0d]: got %0d want %0d", i, grant_owner[i], exp_owner[i]); end
                n_cmp++; if (grant_cycle[i] != exp_cycle[i]) begin n_fail++; $display("[TB] FAIL fair_grant_cycle[%0d]: got %0d want %0d", i, grant_cycle[i], exp_cycle[i]); end
            end
        end
        n_cmp++;
        if (beats_seen.size() < 12) begin
            n_fail++;
            $display("[TB] FAIL fair_beat_count: got %0d want >=12", beats_seen.size());
        end else begin
            for (int i = 0; i < 12; i++) begin
                n_cmp++; if (beats_seen[i] !== exp_val[i / 4]) begin n_fail++; $display("[TB] FAIL fair_beat[%0d]: got %0d want %0d", i, beats_seen[i], exp_val[i / 4]); end
            end
        end
    endtask

    task automatic test_early_release();
        int nbeats;
        do_reset();
        req2 = 1'b1;
        tick();
        n_cmp++; if (gv !== 3'b010) begin n_fail++; $display("[TB] FAIL early_gnt: got %b want 010", gv); end
        nbeats = 0;
        repeat (2) begin
            tick();
            if (op_valid && mux_op == 4'd4) nbeats++;
        end
        req2 = 1'b0;
        tick();
        if (op_valid) nbeats++;
        n_cmp++; if (nbeats != 2) begin n_fail++; $display("[TB] FAIL early_beats: got %0d want 2", nbeats); end
        n_cmp++; if (gv !== 3'b000) begin n_fail++; $display("[TB] FAIL early_idle: got %b want 000", gv); end
        req1 = 1'b1;
        req2 = 1'b1;
        req3 = 1'b1;
        tick();
        n_cmp++; if (gv !== 3'b100) begin n_fail++; $display("[TB] FAIL early_next_gnt: got %b want 100", gv); end
    endtask

    task automatic test_backpressure();
        int nbeats;
        do_reset();
        req1 = 1'b1;
        tick();
        op_ready = 1'b0;
        tick();
        n_cmp++; if (op_valid !== 1'b1 || mux_op !== 4'd2) begin n_fail++; $display("[TB] FAIL bp_first_beat: got v=%b d=%0d want v=1 d=2", op_valid, mux_op); end
        repeat (5) begin
            tick();
            n_cmp++; if (op_valid !== 1'b1 || mux_op !== 4'd2 || gv !== 3'b001) begin n_fail++; $display("[TB] FAIL bp_stall: got v=%b d=%0d g=%b want v=1 d=2 g=001", op_valid, mux_op, gv); end
        end
        op_ready = 1'b1;
        nbeats = 0;
        repeat (3) begin
            tick();
            if (op_valid && mux_op == 4'd2) nbeats++;
        end
        n_cmp++; if (nbeats != 3) begin n_fail++; $display("[TB] FAIL bp_remaining: got %0d want 3", nbeats); end
        n_cmp++; if (gv !== 3'b000) begin n_fail++; $display("[TB] FAIL bp_burst_end: got %b want 000", gv); end
    endtask

    task automatic test_mid_reset();
        do_reset();
        req3 = 1'b1;
        repeat (3) tick();
        n_cmp++; if (op_valid !== 1'b1 || mux_op !== 4'd8 || gv !== 3'b100) begin n_fail++; $display("[TB] FAIL midrst_pre: got v=%b d=%0d g=%b want v=1 d=8 g=100", op_valid, mux_op, gv); end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (gv !== 3'b000 || sv !== 3'b000) begin n_fail++; $display("[TB] FAIL midrst_async_gnt: got g=%b s=%b want 000", gv, sv); end
        n_cmp++; if (op_valid !== 1'b0 || mux_op !== 4'd0) begin n_fail++; $display("[TB] FAIL midrst_async_out: got v=%b d=%0d want 0", op_valid, mux_op); end
        req1 = 1'b1;
        tick();
        n_cmp++; if (gv !== 3'b000 || op_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL midrst_held: got g=%b v=%b want 000/0", gv, op_valid); end
        #2;
        rst_n = 1'b1;
        tick();
        n_cmp++; if (gv !== 3'b001) begin n_fail++; $display("[TB] FAIL midrst_ptr: got %b want 001", gv); end
    endtask

    task automatic test_random();
        int         dut_acc;
        logic [2:0] exp_g;
        do_reset();
        model_reset();
        dut_acc = 0;
        for (int c = 0; c < 1000; c++) begin
            req1     = ($urandom_range(0, 3) != 0);
            req2     = ($urandom_range(0, 3) != 0);
            req3     = ($urandom_range(0, 3) != 0);
            op_ready = ($urandom_range(0, 2) != 0);
            ip1      = 4'($urandom);
            ip2      = 4'($urandom);
            ip3      = 4'($urandom);
            if (op_valid && op_ready) dut_acc++;
            model_step({req3, req2, req1}, op_ready, ip1, ip2, ip3);
            tick();
            exp_g = (m_owner == 0) ? 3'b000 : 3'(3'b001 << (m_owner - 1));
            n_cmp++; if (gv !== exp_g) begin n_fail++; $display("[TB] FAIL rand_gnt c=%0d: got %b want %b", c, gv, exp_g); end
            n_cmp++; if (sv !== gv || $countones(sv) > 1) begin n_fail++; $display("[TB] FAIL rand_sel c=%0d: got sel=%b gnt=%b", c, sv, gv); end
            n_cmp++; if (op_valid !== (m_valid != 0)) begin n_fail++; $display("[TB] FAIL rand_valid c=%0d: got %b want %0d", c, op_valid, m_valid); end
            n_cmp++; if (mux_op !== m_data) begin n_fail++; $display("[TB] FAIL rand_data c=%0d: got %0d want %0d", c, mux_op, m_data); end
        end
        n_cmp++; if (dut_acc + (op_valid ? 1 : 0) != m_caps) begin n_fail++; $display("[TB] FAIL rand_beat_count: got %0d want %0d", dut_acc + (op_valid ? 1 : 0), m_caps); end
    endtask

    // Scenario sequence followed by the summary line.
    initial begin
        $display("[TB] start");
        test_reset();
        test_fairness();
        test_early_release();
        test_backpressure();
        test_mid_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
